// File: rtl/ifetch_pc.sv
// Instruction-fetch PC register and single-outstanding fetch sequencer.
// Latency: request one cycle after leaving reset; inst_valid two cycles after request entry when memory is ready and responds at once.
// Backpressure: holds imem_req_valid/imem_addr stable until imem_req_ready; holds pc/inst until pc_adv.
//
// Ports:
//   cpu_clk, cpu_rstn         - clock, synchronous active-low reset
//   npc, pc_adv               - next PC from the next-PC unit, advance strobe
//   pc                        - current PC
//   imem_req_valid/ready/addr - fetch request channel
//   imem_resp_valid/data      - fetch response channel
//   inst, inst_valid          - held instruction for pc
//   fetch_err                 - sticky misaligned-npc flag
//   fetch_cnt                 - completed fetch counter (wraps)
module ifetch_pc #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rstn,
  input  logic [31:0] npc,
  input  logic        pc_adv,
  output logic [31:0] pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        fetch_err_q, fetch_err_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    fetch_err_d = fetch_err_q;
    fetch_cnt_d = fetch_cnt_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        // Only one request in flight: accepted request waits for its response.
        if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_resp_valid) begin
          inst_d      = imem_resp_data;
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (pc_adv) begin
          if (npc[1:0] == 2'b00) begin
            pc_d    = npc;
            state_d = S_REQ;
          end else begin
            // Misaligned target: freeze pc and stop fetching until reset.
            fetch_err_d = 1'b1;
            state_d     = S_ERR;
          end
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (!cpu_rstn) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      inst_q      <= 32'd0;
      fetch_err_q <= 1'b0;
      fetch_cnt_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      fetch_err_q <= fetch_err_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Moore outputs: decoded from registered state only.
  assign pc             = pc_q;
  assign imem_addr      = pc_q;
  assign imem_req_valid = (state_q == S_REQ);
  assign inst_valid     = (state_q == S_HOLD);
  assign inst           = inst_q;
  assign fetch_err      = fetch_err_q;
  assign fetch_cnt      = fetch_cnt_q;

endmodule
